spi_slave_multiport_rw: RTL and testbench
=========================================

// Module: spi_slave_multiport_rw
// PURPOSE
//  Oversampled SPI slave (mode 0, MSB first, cs active-low) giving the host read and write access to NCH parallel ports.
//  Serves an address window BASE_ADR..BASE_ADR+NCH-1; supports burst transfers with channel auto-increment.
//  Read data is fetched through a per-channel rd_req/rd_ok handshake, e.g. to an SDRAM read path.
//  Successor of the single-port read-only SPI block.
// PARAMETERS
//  NBIT      8  data word width per channel (4..32)
//  NCH       4  number of channels (1..16); BASE_ADR+NCH-1 <= 127
//  BASE_ADR  1  7-bit address of channel 0
//  SYNC      3  synchroniser depth for sclk/cs/mosi (>=2)
// PORTS
//  clk     in   1         system clock; >= 8x sclk frequency
//  rst     in   1         asynchronous reset, active-high
//  sclk    in   1         SPI clock (async)
//  mosi    in   1         SPI data in (async)
//  cs      in   1         SPI chip select, active-low (async)
//  miso    out  1         SPI data out; idle level 1
//  inport  in   NCH*NBIT  read data; channel k = inport[k*NBIT +: NBIT]
//  rd_req  out  NCH       read request, one-hot level
//  rd_ok   in   NCH       read acknowledge; inport slice valid while high
//  outport out  NBIT      last written word
//  wr_stb  out  NCH       one-hot 1-cycle strobe; outport valid in the same cycle
//  err     out  1         1-cycle pulse: read underrun (rd_ok late)
// BEHAVIOUR
//  - Reset (async, any state): miso=1, rd_req=0, wr_stb=0, outport=0, err=0, state IDLE, counters 0.
//  - sclk, cs and mosi pass through SYNC flops; edges are taken from the last two stages.
//    Edge-to-action latency is SYNC clk cycles.
//  - Rising sclk edge: sample mosi. Falling sclk edge: update miso.
//  - States: IDLE, CMD, REQ, RD, WR, SKIP.
//    IDLE -> CMD: cs falling edge; bit counter cleared.
//    CMD: shift in 8 bits. Bit7 = R/W (0 read, 1 write), bits[6:0] = address.
//    CMD -> REQ: read command, address in window; ch = adr - BASE_ADR; rd_req[ch]=1.
//    CMD -> WR: write command, address in window.
//    CMD -> SKIP: address outside window; miso stays 1 until cs rises.
//    REQ: on rd_ok[ch], load the inport slice into the shift register, drive miso=MSB at once, drop rd_req, -> RD.
//    RD: each falling sclk shifts the next bit onto miso. After NBIT rising edges, ch = ch+1.
//      Channel wraps NCH-1 -> 0.
//      rd_req for the new ch is asserted at once and the state returns to REQ (burst).
//    WR: shift in NBIT bits. On the NBIT-th rising edge: outport <= word; wr_stb[ch] pulses 1 cycle; ch = ch+1 with wrap; stay in WR.
//  - Underrun: a rising sclk in REQ (first data bit arrives before rd_ok).
//    err pulses once; the word is sent as all-ones; rd_req is dropped; state -> RD.
//    A rd_ok that arrives after this is ignored.
//  - cs rising edge in any state -> IDLE in the same cycle.
//    rd_req=0, miso=1. A partial word is discarded: no wr_stb, and outport keeps its value.
//  - cs rising edge and NBIT-th rising sclk edge in the same cycle: complete the word (wr_stb fires), then go to IDLE.
//  - Edges on sclk while cs is high are ignored.
//  - miso is registered; it is never driven from combinational logic.
// STRUCTURE
//  - Shared package spi_slave_pkg holds:
//    state enum; CMD_RW_BIT=7; CMD_ADR_W=7; constants RD=0, WR=1.
//  - Sub-module spi_edge_sync: SYNC-stage synchroniser plus rise/fall pulse outputs.
//    Instanced for sclk and cs; mosi uses its sync output only.
//  - Top level holds the FSM, bit counter ($clog2(NBIT+1) bits), channel index ($clog2(NCH) bits, min 1) and shift register.
// TESTING (NBIT=8, NCH=4, BASE_ADR=1, clk=8x sclk)
//  1 Read, rd_ok 2 clk after rd_req: cmd 0x02 with inport ch1 = 0xA5.
//    -> rd_req=0010 then 0; miso shifts 10100101; miso=1 after cs rises.
//  2 Burst write: cmd 0x84 + 0x11,0x22.
//    -> wr_stb=1000 with outport=0x11, then wr_stb=0001 with outport=0x22 (wrap).
//  3 Out of window: cmd 0x10 + 8 clocks.
//    -> no rd_req, no wr_stb, miso constantly 1.
//  4 Underrun: cmd 0x01 with rd_ok held low.
//    -> one err pulse; miso = 0xFF; rd_req cleared at the first data edge.
//  5 Abort: cs raised after 5 data bits of a write to ch2.
//    -> no wr_stb; outport unchanged; FSM in IDLE; the next transaction works.
//  6 Reset mid-read: assert rst while rd_req=0100.
//    -> rd_req=0 and miso=1 without waiting for a clk edge.

Source files
------------

// File: rtl/spi_slave_multiport_rw_pkg.sv
// rtl/spi_slave_multiport_rw_pkg.sv - shared types and command-format constants for the SPI multiport slave
package spi_slave_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_REQ,
        ST_RD,
        ST_WR,
        ST_SKIP
    } state_t;

    localparam int   CMD_RW_BIT = 7;
    localparam int   CMD_ADR_W  = 7;
    localparam logic RD         = 1'b0;
    localparam logic WR         = 1'b1;

endpackage

// File: rtl/spi_slave_multiport_rw_if.sv
// rtl/spi_slave_multiport_rw_if.sv - SPI pins plus parallel read/write port bundle
interface spi_slave_multiport_rw_if #(
    parameter int NBIT = 8,
    parameter int NCH  = 4
);
    logic                sclk;
    logic                mosi;
    logic                cs;
    logic                miso;
    logic [NCH*NBIT-1:0] inport;
    logic [NCH-1:0]      rd_req;
    logic [NCH-1:0]      rd_ok;
    logic [NBIT-1:0]     outport;
    logic [NCH-1:0]      wr_stb;
    logic                err;

    modport slave (
        input  sclk, mosi, cs, inport, rd_ok,
        output miso, rd_req, outport, wr_stb, err
    );

    modport master (
        output sclk, mosi, cs, inport, rd_ok,
        input  miso, rd_req, outport, wr_stb, err
    );
endinterface

// File: rtl/spi_slave_multiport_rw_edge_sync.sv
// rtl/spi_slave_multiport_rw_edge_sync.sv - multi-stage synchroniser with rise/fall pulse outputs
module spi_edge_sync #(
    parameter int   SYNC    = 3,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise,
    output logic fall
);
    logic [SYNC-1:0] sr;

    // Shift the async input through SYNC flops; bit 0 is the newest sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= {SYNC{RST_VAL}};
        end else begin
            sr <= {sr[SYNC-2:0], d};
        end
    end

    assign rise = sr[SYNC-2] & ~sr[SYNC-1];
    assign fall = ~sr[SYNC-2] & sr[SYNC-1];
endmodule

// File: rtl/spi_slave_multiport_rw.sv
// rtl/spi_slave_multiport_rw.sv - oversampled mode-0 SPI slave with NCH read/write parallel ports
module spi_slave_multiport_rw
    import spi_slave_pkg::*;
#(
    parameter int NBIT     = 8,
    parameter int NCH      = 4,
    parameter int BASE_ADR = 1,
    parameter int SYNC     = 3
) (
    input logic                   clk,
    input logic                   rst,
    spi_slave_multiport_rw_if.slave bus
);
    // The shift register also assembles the 8-bit command, so it is never narrower than 8
    localparam int SW  = (NBIT > 8) ? NBIT : 8;
    localparam int CW  = $clog2(SW + 1);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [CW-1:0]        CMD_LAST  = CW'(7);
    localparam logic [CW-1:0]        WORD_LAST = CW'(NBIT - 1);
    localparam logic [CHW-1:0]       CH_LAST   = CHW'(NCH - 1);
    localparam logic [CMD_ADR_W-1:0] ADR_LO    = CMD_ADR_W'(BASE_ADR);
    localparam logic [CMD_ADR_W-1:0] ADR_HI    = CMD_ADR_W'(BASE_ADR + NCH - 1);
    localparam logic [NCH-1:0]       CH_ONE    = NCH'(1);

    logic sclk_rise, sclk_fall, cs_rise, cs_fall;

    spi_edge_sync #(.SYNC(SYNC), .RST_VAL(1'b0)) u_sclk_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (bus.sclk),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    spi_edge_sync #(.SYNC(SYNC), .RST_VAL(1'b1)) u_cs_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (bus.cs),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    // mosi is delayed by SYNC-1 flops so its value lines up with the sclk edge pulses
    logic [SYNC-2:0] mosi_sr;
    logic            mosi_s;

    // mosi synchroniser chain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mosi_sr <= '0;
        end else begin
            mosi_sr <= (SYNC-1)'({mosi_sr, bus.mosi});
        end
    end

    assign mosi_s = mosi_sr[SYNC-2];

    state_t          state;
    logic [CW-1:0]   bit_cnt;
    logic [CHW-1:0]  ch;
    logic [SW-1:0]   sreg;
    logic            miso_r;
    logic [NCH-1:0]  rd_req_r;
    logic [NBIT-1:0] outport_r;
    logic [NCH-1:0]  wr_stb_r;
    logic            err_r;

    logic [SW-1:0]        sreg_in;
    logic [7:0]           cmd_byte;
    logic [CMD_ADR_W-1:0] cmd_adr;
    logic                 cmd_hit;
    logic [CHW-1:0]       cmd_ch;
    logic [CHW-1:0]       ch_nxt;
    logic [NBIT-1:0]      rd_word;
    logic                 word_done;

    assign sreg_in   = {sreg[SW-2:0], mosi_s};
    assign cmd_byte  = sreg_in[7:0];
    assign cmd_adr   = cmd_byte[CMD_ADR_W-1:0];
    assign cmd_hit   = (cmd_adr >= ADR_LO) && (cmd_adr <= ADR_HI);
    assign cmd_ch    = CHW'(cmd_adr - ADR_LO);
    assign ch_nxt    = (ch == CH_LAST) ? '0 : ch + CHW'(1);
    assign rd_word   = bus.inport[ch*NBIT +: NBIT];
    assign word_done = sclk_rise && (bit_cnt == WORD_LAST);

    // Transaction FSM; every output is a register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            ch        <= '0;
            sreg      <= '0;
            miso_r    <= 1'b1;
            rd_req_r  <= '0;
            outport_r <= '0;
            wr_stb_r  <= '0;
            err_r     <= 1'b0;
        end else begin
            wr_stb_r <= '0;
            err_r    <= 1'b0;
            if (cs_rise) begin
                // A word whose last bit lands together with cs release still counts
                if (state == ST_WR && word_done) begin
                    outport_r <= sreg_in[NBIT-1:0];
                    wr_stb_r  <= CH_ONE << ch;
                end
                state    <= ST_IDLE;
                rd_req_r <= '0;
                miso_r   <= 1'b1;
                bit_cnt  <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (cs_fall) begin
                            state   <= ST_CMD;
                            bit_cnt <= '0;
                        end
                    end
                    ST_CMD: begin
                        if (sclk_rise) begin
                            sreg <= sreg_in;
                            if (bit_cnt == CMD_LAST) begin
                                bit_cnt <= '0;
                                ch      <= cmd_ch;
                                if (!cmd_hit) begin
                                    state <= ST_SKIP;
                                end else if (cmd_byte[CMD_RW_BIT] == WR) begin
                                    state <= ST_WR;
                                end else begin
                                    state    <= ST_REQ;
                                    rd_req_r <= CH_ONE << cmd_ch;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + CW'(1);
                            end
                        end
                    end
                    ST_REQ: begin
                        if (sclk_rise) begin
                            // Host clocked a data bit before the word arrived: send ones
                            err_r    <= 1'b1;
                            sreg     <= '1;
                            miso_r   <= 1'b1;
                            rd_req_r <= '0;
                            bit_cnt  <= CW'(1);
                            state    <= ST_RD;
                        end else if (bus.rd_ok[ch]) begin
                            sreg     <= SW'({rd_word[NBIT-2:0], 1'b1});
                            miso_r   <= rd_word[NBIT-1];
                            rd_req_r <= '0;
                            state    <= ST_RD;
                        end
                    end
                    ST_RD: begin
                        if (sclk_rise) begin
                            if (bit_cnt == WORD_LAST) begin
                                bit_cnt  <= '0;
                                ch       <= ch_nxt;
                                rd_req_r <= CH_ONE << ch_nxt;
                                state    <= ST_REQ;
                            end else begin
                                bit_cnt <= bit_cnt + CW'(1);
                            end
                        end else if (sclk_fall && bit_cnt != '0) begin
                            // The trailing fall of the previous byte (bit_cnt 0) must not shift
                            miso_r <= sreg[NBIT-1];
                            sreg   <= {sreg[SW-2:0], 1'b1};
                        end
                    end
                    ST_WR: begin
                        if (sclk_rise) begin
                            sreg <= sreg_in;
                            if (bit_cnt == WORD_LAST) begin
                                outport_r <= sreg_in[NBIT-1:0];
                                wr_stb_r  <= CH_ONE << ch;
                                ch        <= ch_nxt;
                                bit_cnt   <= '0;
                            end else begin
                                bit_cnt <= bit_cnt + CW'(1);
                            end
                        end
                    end
                    ST_SKIP: begin
                        state <= ST_SKIP;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.miso    = miso_r;
    assign bus.rd_req  = rd_req_r;
    assign bus.outport = outport_r;
    assign bus.wr_stb  = wr_stb_r;
    assign bus.err     = err_r;
endmodule

// File: tb/tb_spi_slave_multiport_rw.sv
// tb/tb_spi_slave_multiport_rw.sv - directed scoreboard bench for spi_slave_multiport_rw
module tb_spi_slave_multiport_rw;
    import spi_slave_pkg::*;

    logic clk;
    logic rst;

    spi_slave_multiport_rw_if #(.NBIT(8), .NCH(4)) bus ();

    spi_slave_multiport_rw #(.NBIT(8), .NCH(4), .BASE_ADR(1), .SYNC(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] stb;
        logic [7:0] data;
    } wr_exp_t;

    wr_exp_t    wr_q[$];
    logic [7:0] rd_q[$];

    int   n_checks = 0;
    int   n_fail   = 0;
    int   err_cnt  = 0;
    int   wr_seen  = 0;
    logic [3:0] rd_req_or = '0;
    logic miso_low = 1'b0;
    logic rd_en    = 1'b1;
    int   rd_dly   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Read-side responder: rd_ok follows rd_req two clocks later while enabled
    initial begin
        bus.rd_ok = '0;
        forever begin
            @(negedge clk);
            if (!rd_en || bus.rd_req === '0) begin
                bus.rd_ok = '0;
                rd_dly    = 0;
            end else begin
                rd_dly++;
                if (rd_dly >= 2) bus.rd_ok = bus.rd_req;
            end
        end
    end

    // Output monitor: write strobes are popped from the scoreboard as they appear
    initial begin
        forever begin
            @(negedge clk);
            if (bus.err === 1'b1) err_cnt++;
            if (!$isunknown(bus.rd_req)) rd_req_or |= bus.rd_req;
            if (bus.cs === 1'b0 && bus.miso === 1'b0) miso_low = 1'b1;
            if (bus.wr_stb !== '0) begin
                wr_seen++;
                if (wr_q.size() == 0) begin
                    check("wr_unexpected", 32'(bus.wr_stb), 32'h0);
                end else begin
                    wr_exp_t e;
                    e = wr_q.pop_front();
                    check("wr_stb", 32'(bus.wr_stb), 32'(e.stb));
                    check("wr_outport", 32'(bus.outport), 32'(e.data));
                end
            end
        end
    end

    task automatic spi_bit(input logic b, output logic r);
        bus.mosi = b;
        repeat (4) @(negedge clk);
        bus.sclk = 1'b1;
        r = bus.miso;
        repeat (4) @(negedge clk);
        bus.sclk = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) spi_bit(tx[i], rx[i]);
    endtask

    task automatic spi_start();
        bus.cs = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic spi_end();
        repeat (4) @(negedge clk);
        bus.cs = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic rd_check(input string tag, input logic [7:0] rx);
        if (rd_q.size() == 0) begin
            check({tag, "_noexp"}, 32'(rx), 32'hFFFF_FFFF);
        end else begin
            logic [7:0] e;
            e = rd_q.pop_front();
            check(tag, 32'(rx), 32'(e));
        end
    endtask

    initial begin
        logic [7:0] rx;
        logic [7:0] w;
        logic       r;
        int         err_base;
        int         wr_base;

        rst        = 1'b1;
        bus.sclk   = 1'b0;
        bus.cs     = 1'b1;
        bus.mosi   = 1'b0;
        bus.inport = {8'h96, 8'h5A, 8'hA5, 8'h3C};
        repeat (3) @(negedge clk);
        check("rst_miso", 32'(bus.miso), 32'h1);
        check("rst_rd_req", 32'(bus.rd_req), 32'h0);
        check("rst_wr_stb", 32'(bus.wr_stb), 32'h0);
        check("rst_outport", 32'(bus.outport), 32'h0);
        check("rst_err", 32'(bus.err), 32'h0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // 1: single read of channel 1, burst continues into channel 2
        rd_req_or = '0;
        spi_start();
        spi_byte(8'h02, rx);
        repeat (2) @(negedge clk);
        check("t1_req_seen", 32'(rd_req_or), 32'h2);
        check("t1_req_drop", 32'(bus.rd_req), 32'h0);
        rd_q.push_back(8'hA5);
        spi_byte(8'h00, rx);
        rd_check("t1_rx", rx);
        spi_end();
        check("t1_req_burst", 32'(rd_req_or), 32'h6);
        check("t1_miso_idle", 32'(bus.miso), 32'h1);
        check("t1_req_idle", 32'(bus.rd_req), 32'h0);

        // 2: burst write to channel 3 wrapping to channel 0
        wr_q.push_back('{stb: 4'b1000, data: 8'h11});
        wr_q.push_back('{stb: 4'b0001, data: 8'h22});
        spi_start();
        spi_byte(8'h84, rx);
        spi_byte(8'h11, rx);
        spi_byte(8'h22, rx);
        spi_end();
        check("t2_wr_q_empty", 32'(wr_q.size()), 32'h0);
        check("t2_outport", 32'(bus.outport), 32'h22);

        // 3: address outside the window
        rd_req_or = '0;
        miso_low  = 1'b0;
        wr_base   = wr_seen;
        rd_q.push_back(8'hFF);
        spi_start();
        spi_byte(8'h10, rx);
        spi_byte(8'h00, rx);
        rd_check("t3_rx", rx);
        spi_end();
        check("t3_no_req", 32'(rd_req_or), 32'h0);
        check("t3_no_wr", 32'(wr_seen - wr_base), 32'h0);
        check("t3_miso_high", 32'(miso_low), 32'h0);

        // 4: underrun on channel 0
        rd_en    = 1'b0;
        err_base = err_cnt;
        rd_q.push_back(8'hFF);
        spi_start();
        spi_byte(8'h01, rx);
        check("t4_req_pending", 32'(bus.rd_req), 32'h1);
        spi_bit(1'b0, r);
        rx[7] = r;
        check("t4_req_cleared", 32'(bus.rd_req), 32'h0);
        check("t4_err_first", 32'(err_cnt - err_base), 32'h1);
        for (int i = 6; i >= 0; i--) begin
            spi_bit(1'b0, r);
            rx[i] = r;
        end
        rd_check("t4_rx", rx);
        spi_end();
        check("t4_err_once", 32'(err_cnt - err_base), 32'h1);
        rd_en = 1'b1;

        // 5: abort a write to channel 2 after 5 data bits, then a clean write
        wr_base = wr_seen;
        spi_start();
        spi_byte(8'h83, rx);
        for (int i = 0; i < 5; i++) spi_bit(1'b1, r);
        spi_end();
        check("t5_no_wr", 32'(wr_seen - wr_base), 32'h0);
        check("t5_outport_kept", 32'(bus.outport), 32'h22);
        check("t5_state_idle", 32'(dut.state), 32'(ST_IDLE));
        wr_q.push_back('{stb: 4'b0010, data: 8'h77});
        spi_start();
        spi_byte(8'h82, rx);
        spi_byte(8'h77, rx);
        spi_end();
        check("t5_next_outport", 32'(bus.outport), 32'h77);

        // cs release together with the last rising sclk of a write
        w = 8'hC3;
        wr_q.push_back('{stb: 4'b0001, data: 8'hC3});
        spi_start();
        spi_byte(8'h81, rx);
        for (int i = 7; i >= 1; i--) spi_bit(w[i], r);
        bus.mosi = w[0];
        repeat (4) @(negedge clk);
        bus.sclk = 1'b1;
        bus.cs   = 1'b1;
        repeat (4) @(negedge clk);
        bus.sclk = 1'b0;
        repeat (6) @(negedge clk);
        check("tc_outport", 32'(bus.outport), 32'hC3);
        check("tc_state_idle", 32'(dut.state), 32'(ST_IDLE));

        // 6: asynchronous reset while channel 2 is being requested
        bus.inport[15:8] = 8'hA4;
        spi_start();
        spi_byte(8'h02, rx);
        repeat (2) @(negedge clk);
        rd_en = 1'b0;
        rd_q.push_back(8'hA4);
        spi_byte(8'h00, rx);
        rd_check("t6_rx", rx);
        repeat (2) @(negedge clk);
        check("t6_req_pending", 32'(bus.rd_req), 32'h4);
        check("t6_miso_lsb", 32'(bus.miso), 32'h0);
        #2 rst = 1'b1;
        #1;
        check("t6_async_req", 32'(bus.rd_req), 32'h0);
        check("t6_async_miso", 32'(bus.miso), 32'h1);
        check("t6_async_outport", 32'(bus.outport), 32'h0);
        @(negedge clk);
        bus.cs = 1'b1;
        rst    = 1'b0;
        rd_en  = 1'b1;
        repeat (6) @(negedge clk);

        check("end_wr_q", 32'(wr_q.size()), 32'h0);
        check("end_rd_q", 32'(rd_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
